mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction and data caches and upstream of the RAM model/controller.
- Arbitrates single-word icache fills and multi-word dcache block transfers (writeback/load) onto one RAM port.
- Dcache has priority, with anti-starvation for the icache.
- Holds the grant across a whole dcache block so the two words of a block are never interleaved with icache traffic.

Parameters:
- ADDR_W, 32, address width (word_t).
- DATA_W, 32, data width (word_t).
- BURST_LEN, 2, words per dcache block transfer; icache transfers are always 1 word.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache word address
- iwait  out  1  icache stall; low only in the completing cycle
- iload  out  DATA_W  icache read data
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache word address
- dstore  in  DATA_W  dcache write data
- dwait  out  1  dcache stall; low only in the completing cycle
- dload  out  DATA_W  dcache read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- State machine, registered: IDLE, DGNT, IGNT. Registered beat counter `beat`, width clog2(BURST_LEN)+1.
- Reset (RST high, async): state=IDLE, beat=0.
- RAM-side and load outputs are combinational from state and inputs. In IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0, iload=dload=0, iwait=dwait=1.
- Arbitration latency: 1 cycle. A request seen in IDLE moves to a grant state on the next edge; no RAM access is issued from IDLE.
- IDLE -> DGNT if dREN|dWEN; else -> IGNT if iREN; else stay.
- DGNT:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN; ramREN=dREN&~dWEN. Write wins when both are asserted.
  - dload=ramload; dwait=~(ramstate==ACCESS).
  - iwait=1, iload=0.
- DGNT completion: each ACCESS cycle is one beat and increments `beat`.
  - On the ACCESS with beat==BURST_LEN-1: beat<=0, then -> IGNT if iREN, else -> IDLE. The icache gets the next slot even if the dcache re-requests (anti-starvation).
- DGNT abort: if dREN|dWEN drops before the burst completes -> IDLE, beat<=0. No RAM enables in that cycle.
- IGNT:
  - ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0.
  - iload=ramload; iwait=~(ramstate==ACCESS).
  - dwait=1, dload=0.
- IGNT completion: on ACCESS -> DGNT if dREN|dWEN, else IDLE. If iREN drops -> IDLE.
- ramstate BUSY, FREE or ERROR in a grant state: stall (wait=1), no beat counted, stay in state.
- Address changes between beats (LD1->LD2) are passed through unmodified; the arbiter does not check them.
- Reset mid-burst: state and beat are cleared immediately and the enables drop asynchronously.

Optional Feature:
- Macro: ARB_PERF_EN.
- When defined, adds the following output ports:
  - icnt (32): icache completed words.
  - dcnt (32): dcache completed words.
  - stallcnt (32): cycles with any wait=1 while that master requested.
- Counters are reset to 0 by RST and wrap modulo 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Existing cpu_types_pkg: word_t, plus ramstate_t enum (FREE, BUSY, ACCESS, ERROR).
- Local to the block: arb_state_t {IDLE, DGNT, IGNT}.
- No sub-module; the optional perf counters stay inline under the macro.

Test Plan:
- Reset, then idle cycles -> ramREN=ramWEN=0, iwait=dwait=1, iload=dload=0. Assert RST mid-DGNT -> state IDLE within the same cycle.
- iREN=1 at iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF:
  - First cycle: no ramREN.
  - Then ramaddr=0x40 with ramREN=1.
  - iwait low for exactly 1 cycle with iload=0xDEADBEEF.
- dWEN burst, daddr 0x100 then 0x104, dstore 0x11 then 0x22, with iREN held high throughout:
  - Two ACCESS beats with ramWEN=1 and the correct addr/data.
  - iREN never granted mid-burst.
  - Next state IGNT.
- dREN and iREN rise in the same IDLE cycle, and dREN is re-raised right after the block completes -> dcache served first, then icache, then dcache.
- dREN and dWEN both high -> ramWEN=1, ramREN=0. dREN drops after beat 0 -> IDLE, beat reset; next dcache burst takes 2 full beats.
- With ARB_PERF_EN defined: 3 icache words and 1 dcache block -> icnt=3, dcnt=2. stallcnt equals the counted stall cycles.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM status encoding.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Icache/dcache to single RAM port arbiter; dcache priority, grant held for a whole block.
// Optional perf counters (icnt, dcnt, stallcnt) are built when ARB_PERF_EN is defined.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate,
`ifdef ARB_PERF_EN
    output logic [31:0]       icnt,
    output logic [31:0]       dcnt,
    output logic [31:0]       stallcnt,
`endif
    output logic [1:0]        arb_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DGNT = 2'd1,
        IGNT = 2'd2
    } arb_state_t;

    localparam int                BEAT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    arb_state_t        state;
    logic [BEAT_W-1:0] beat;
    logic              dreq;
    logic              access;

    assign dreq      = dREN | dWEN;
    assign access    = (ramstate == ACCESS);
    assign arb_state = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq)      state <= DGNT;
                    else if (iREN) state <= IGNT;
                end
                DGNT: begin
                    if (!dreq) begin
                        state <= IDLE;
                        beat  <= '0;
                    end else if (access) begin
                        if (beat == LAST_BEAT) begin
                            // Icache takes the next slot even if the dcache asks again.
                            beat  <= '0;
                            state <= iREN ? IGNT : IDLE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                IGNT: begin
                    if (!iREN)       state <= IDLE;
                    else if (access) state <= dreq ? DGNT : IDLE;
                end
                default: begin
                    state <= IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state)
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dload    = ramload;
                dwait    = ~access;
            end
            IGNT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iload   = ramload;
                iwait   = ~access;
            end
            default: ;
        endcase
    end

`ifdef ARB_PERF_EN
    logic stall;
    assign stall = (iwait & iREN) | (dwait & dreq);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            icnt     <= '0;
            dcnt     <= '0;
            stallcnt <= '0;
        end else begin
            if (state == IGNT && iREN && access) icnt <= icnt + 32'd1;
            if (state == DGNT && dreq && access) dcnt <= dcnt + 32'd1;
            if (stall)                           stallcnt <= stallcnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs are checked 1ns later.
// Perf counter checks are built only when ARB_PERF_EN is defined.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DGNT = 2'd1;
    localparam logic [1:0] S_IGNT = 2'd2;

    logic        clk;
    logic        rst;
    logic        iren;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;
    logic [1:0]  arb_state;
`ifdef ARB_PERF_EN
    logic [31:0] icnt;
    logic [31:0] dcnt;
    logic [31:0] stallcnt;
`endif

    int vecs = 0;
    int errs = 0;

    mem_arbiter dut (
        .CLK      (clk),
        .RST      (rst),
        .iREN     (iren),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dren),
        .dWEN     (dwen),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ram_ren),
        .ramWEN   (ram_wen),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
`ifdef ARB_PERF_EN
        .icnt     (icnt),
        .dcnt     (dcnt),
        .stallcnt (stallcnt),
`endif
        .arb_state(arb_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one cycle of inputs on the falling edge, then let combinational outputs settle
    task automatic cyc(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] ds,
                       input logic [1:0] rs, input logic [31:0] rl);
        @(negedge clk);
        iren     = ir;
        iaddr    = ia;
        dren     = dr;
        dwen     = dw;
        daddr    = da;
        dstore   = ds;
        ramstate = ramstate_t'(rs);
        ramload  = rl;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        iren = 1'b0; iaddr = '0; dren = 1'b0; dwen = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        repeat (2) @(posedge clk);

        // reset and idle
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 32'hFFFF_FFFF);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 2'd2, 32'hFFFF_FFFF);
        check("idle_state", {30'd0, arb_state}, {30'd0, S_IDLE});
        check("idle_ren", {31'd0, ram_ren}, 32'd0);
        check("idle_wen", {31'd0, ram_wen}, 32'd0);
        check("idle_waits", {30'd0, iwait, dwait}, 32'd3);
        check("idle_iload", iload, 32'd0);
        check("idle_dload", dload, 32'd0);
        check("idle_addr", ramaddr, 32'd0);

        // icache read, two BUSY cycles before ACCESS
        cyc(1, 32'h40, 0, 0, 0, 0, 2'd0, 0);
        check("i_first_noren", {31'd0, ram_ren}, 32'd0);
        check("i_first_iwait", {31'd0, iwait}, 32'd1);
        cyc(1, 32'h40, 0, 0, 0, 0, 2'd1, 0);
        check("i_busy1_state", {30'd0, arb_state}, {30'd0, S_IGNT});
        check("i_busy1_ren", {31'd0, ram_ren}, 32'd1);
        check("i_busy1_addr", ramaddr, 32'h40);
        check("i_busy1_iwait", {31'd0, iwait}, 32'd1);
        cyc(1, 32'h40, 0, 0, 0, 0, 2'd1, 0);
        check("i_busy2_iwait", {31'd0, iwait}, 32'd1);
        cyc(1, 32'h40, 0, 0, 0, 0, 2'd2, 32'hDEAD_BEEF);
        check("i_acc_iwait", {31'd0, iwait}, 32'd0);
        check("i_acc_iload", iload, 32'hDEAD_BEEF);
        check("i_acc_dwait", {31'd0, dwait}, 32'd1);
        cyc(1, 32'h40, 0, 0, 0, 0, 2'd1, 32'hDEAD_BEEF);
        check("i_after_state", {30'd0, arb_state}, {30'd0, S_IDLE});
        check("i_after_iwait", {31'd0, iwait}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);

        // dcache write burst with icache requesting throughout
        cyc(1, 32'h44, 0, 1, 32'h100, 32'h11, 2'd0, 0);
        check("w_arb_wen", {31'd0, ram_wen}, 32'd0);
        check("w_arb_ren", {31'd0, ram_ren}, 32'd0);
        cyc(1, 32'h44, 0, 1, 32'h100, 32'h11, 2'd2, 0);
        check("w_b0_state", {30'd0, arb_state}, {30'd0, S_DGNT});
        check("w_b0_wen", {31'd0, ram_wen}, 32'd1);
        check("w_b0_addr", ramaddr, 32'h100);
        check("w_b0_store", ramstore, 32'h11);
        check("w_b0_dwait", {31'd0, dwait}, 32'd0);
        check("w_b0_iwait", {31'd0, iwait}, 32'd1);
        cyc(1, 32'h44, 0, 1, 32'h104, 32'h22, 2'd2, 0);
        check("w_b1_state", {30'd0, arb_state}, {30'd0, S_DGNT});
        check("w_b1_wen", {31'd0, ram_wen}, 32'd1);
        check("w_b1_ren", {31'd0, ram_ren}, 32'd0);
        check("w_b1_addr", ramaddr, 32'h104);
        check("w_b1_store", ramstore, 32'h22);
        check("w_b1_iwait", {31'd0, iwait}, 32'd1);
        cyc(1, 32'h44, 0, 0, 0, 0, 2'd2, 32'h55);
        check("w_next_state", {30'd0, arb_state}, {30'd0, S_IGNT});
        check("w_next_addr", ramaddr, 32'h44);
        check("w_next_iload", iload, 32'h55);
        check("w_next_iwait", {31'd0, iwait}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);
        check("w_end_state", {30'd0, arb_state}, {30'd0, S_IDLE});

        // simultaneous requests, dcache re-requests right after its block
        cyc(1, 32'h80, 1, 0, 32'h200, 0, 2'd0, 0);
        cyc(1, 32'h80, 1, 0, 32'h200, 0, 2'd2, 32'hA1);
        check("r_b0_state", {30'd0, arb_state}, {30'd0, S_DGNT});
        check("r_b0_ren", {31'd0, ram_ren}, 32'd1);
        check("r_b0_dload", dload, 32'hA1);
        check("r_b0_dwait", {31'd0, dwait}, 32'd0);
        cyc(1, 32'h80, 1, 0, 32'h204, 0, 2'd2, 32'hA2);
        check("r_b1_dload", dload, 32'hA2);
        check("r_b1_addr", ramaddr, 32'h204);
        cyc(1, 32'h80, 1, 0, 32'h300, 0, 2'd2, 32'hB1);
        check("r_i_state", {30'd0, arb_state}, {30'd0, S_IGNT});
        check("r_i_addr", ramaddr, 32'h80);
        check("r_i_iload", iload, 32'hB1);
        check("r_i_dwait", {31'd0, dwait}, 32'd1);
        check("r_i_dload", dload, 32'd0);
        cyc(0, 0, 1, 0, 32'h300, 0, 2'd0, 0);
        check("r_d2_state", {30'd0, arb_state}, {30'd0, S_DGNT});
        check("r_d2_addr", ramaddr, 32'h300);
        check("r_d2_dwait_free", {31'd0, dwait}, 32'd1);
        cyc(0, 0, 1, 0, 32'h300, 0, 2'd2, 0);
        cyc(0, 0, 1, 0, 32'h304, 0, 2'd2, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);
        check("r_end_state", {30'd0, arb_state}, {30'd0, S_IDLE});

        // read+write together, then abort after beat 0
        cyc(0, 0, 1, 1, 32'h400, 32'h77, 2'd0, 0);
        cyc(0, 0, 1, 1, 32'h400, 32'h77, 2'd2, 0);
        check("rw_wen", {31'd0, ram_wen}, 32'd1);
        check("rw_ren", {31'd0, ram_ren}, 32'd0);
        check("rw_store", ramstore, 32'h77);
        cyc(0, 0, 0, 0, 32'h404, 32'h88, 2'd0, 0);
        check("ab_wen", {31'd0, ram_wen}, 32'd0);
        check("ab_ren", {31'd0, ram_ren}, 32'd0);
        cyc(0, 0, 0, 1, 32'h500, 32'h99, 2'd0, 0);
        check("ab_state", {30'd0, arb_state}, {30'd0, S_IDLE});
        cyc(0, 0, 0, 1, 32'h500, 32'h99, 2'd2, 0);
        check("ab_b0_dwait", {31'd0, dwait}, 32'd0);
        cyc(0, 0, 0, 1, 32'h504, 32'h9A, 2'd2, 0);
        check("ab_b1_state", {30'd0, arb_state}, {30'd0, S_DGNT});
        check("ab_b1_dwait", {31'd0, dwait}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);
        check("ab_end_state", {30'd0, arb_state}, {30'd0, S_IDLE});

        // reset in the middle of a dcache block
        cyc(0, 0, 1, 0, 32'h600, 0, 2'd0, 0);
        cyc(0, 0, 1, 0, 32'h600, 0, 2'd2, 0);
        check("rs_pre_state", {30'd0, arb_state}, {30'd0, S_DGNT});
        #2 rst = 1'b1;
        #1;
        check("rs_async_state", {30'd0, arb_state}, {30'd0, S_IDLE});
        check("rs_async_ren", {31'd0, ram_ren}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);
        rst = 1'b0;
        cyc(0, 0, 1, 0, 32'h700, 0, 2'd0, 0);
        cyc(0, 0, 1, 0, 32'h700, 0, 2'd2, 0);
        cyc(0, 0, 1, 0, 32'h704, 0, 2'd2, 0);
        check("rs_beat_cleared", {30'd0, arb_state}, {30'd0, S_DGNT});
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);

`ifdef ARB_PERF_EN
        // 3 icache words (one stall cycle each in IDLE) and one 2-beat dcache block (one stall)
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);
        rst = 1'b0;
        check("p_rst_icnt", icnt, 32'd0);
        check("p_rst_stall", stallcnt, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 32'h10 + k, 0, 0, 0, 0, 2'd0, 0);
            cyc(1, 32'h10 + k, 0, 0, 0, 0, 2'd2, 0);
        end
        cyc(0, 0, 1, 0, 32'h800, 0, 2'd0, 0);
        cyc(0, 0, 1, 0, 32'h800, 0, 2'd2, 0);
        cyc(0, 0, 1, 0, 32'h804, 0, 2'd2, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);
        check("p_icnt", icnt, 32'd3);
        check("p_dcnt", dcnt, 32'd2);
        check("p_stallcnt", stallcnt, 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
